// File: rtl/picture_sprite_if.sv
// picture_sprite_if: sprite controls, raster position, ROM port and pixel output (PICTURE_SPRITE_MIRROR_EN adds mirror)
interface picture_sprite_if #(parameter int ADDR_W = 18);
  logic [10:0] x;
  logic [9:0] y;
  logic [10:0] hcount;
  logic [9:0] vcount;
  logic vsync;
  logic [7:0] frame_sel;
  logic [23:0] tint;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0] rom_data;
  logic [23:0] pixel;
  logic pixel_valid;
`ifdef PICTURE_SPRITE_MIRROR_EN
  logic mirror;
`endif
  modport master (
`ifdef PICTURE_SPRITE_MIRROR_EN
    output mirror,
`endif
    output x, y, hcount, vcount, vsync, frame_sel, tint, rom_data,
    input rom_addr, pixel, pixel_valid
  );
  modport slave (
`ifdef PICTURE_SPRITE_MIRROR_EN
    input mirror,
`endif
    input x, y, hcount, vcount, vsync, frame_sel, tint, rom_data,
    output rom_addr, pixel, pixel_valid
  );
endinterface

// File: rtl/picture_sprite.sv
// picture_sprite: tinted, animated ROM sprite overlay with transparent key (PICTURE_SPRITE_MIRROR_EN adds horizontal mirroring)
module picture_sprite #(
  parameter int WIDTH = 72,
  parameter int HEIGHT = 512,
  parameter int FRAMES = 4,
  parameter int ADDR_W = 18,
  parameter int ROM_LAT = 2
) (
  input logic pixel_clk,
  input logic reset,
  picture_sprite_if.slave bus
);
  localparam int FRAME_SZ = WIDTH * HEIGHT;
  logic vs_d;
  logic [10:0] xl;
  logic [9:0] yl;
  logic [7:0] fl;
  logic in_box;
  logic [10:0] col_off;
  logic [9:0] row_off;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] base;
  logic [ROM_LAT:0] dl;
  function automatic logic [7:0] chan(input logic [7:0] d, input logic [7:0] t);
    logic [16:0] p;
    p = 17'(d) * (17'(t) + 17'd1);
    return p[15:8];
  endfunction
  // box test at widened sums so a box past the raster edge clips instead of wrapping
  always_comb begin
    in_box = {1'b0, bus.hcount} >= {1'b0, xl} && {1'b0, bus.hcount} < {1'b0, xl} + 12'(WIDTH) &&
             {1'b0, bus.vcount} >= {1'b0, yl} && {1'b0, bus.vcount} < {1'b0, yl} + 11'(HEIGHT);
    col_off = bus.hcount - xl;
    row_off = bus.vcount - yl;
    base = ADDR_W'(fl) * ADDR_W'(FRAME_SZ);
  end
`ifdef PICTURE_SPRITE_MIRROR_EN
  logic ml;
  assign col = ml ? ADDR_W'(WIDTH - 1) - ADDR_W'(col_off) : ADDR_W'(col_off);
  // mirror flag follows the other controls, latched on the vsync rising edge
  always_ff @(posedge pixel_clk)
    if (reset) ml <= 1'b0;
    else if (bus.vsync && !vs_d) ml <= bus.mirror;
`else
  assign col = ADDR_W'(col_off);
`endif
  // latch position and clamped frame once per vsync rising edge
  always_ff @(posedge pixel_clk)
    if (reset) begin
      vs_d <= 1'b0;
      xl <= '0;
      yl <= '0;
      fl <= '0;
    end else begin
      vs_d <= bus.vsync;
      if (bus.vsync && !vs_d) begin
        xl <= bus.x;
        yl <= bus.y;
        fl <= int'(bus.frame_sel) >= FRAMES ? 8'(FRAMES - 1) : bus.frame_sel;
      end
    end
  // issue ROM address and carry in_box alongside the ROM latency
  always_ff @(posedge pixel_clk)
    if (reset) begin
      bus.rom_addr <= '0;
      dl <= '0;
    end else begin
      bus.rom_addr <= base + (in_box ? ADDR_W'(row_off) * ADDR_W'(WIDTH) + col : '0);
      dl <= {dl[ROM_LAT-1:0], in_box};
    end
  // tint the ROM intensity; zero intensity is the transparent key
  always_ff @(posedge pixel_clk)
    if (reset || !dl[ROM_LAT] || bus.rom_data == 8'h00) begin
      bus.pixel <= '0;
      bus.pixel_valid <= 1'b0;
    end else begin
      bus.pixel <= {chan(bus.rom_data, bus.tint[23:16]), chan(bus.rom_data, bus.tint[15:8]), chan(bus.rom_data, bus.tint[7:0])};
      bus.pixel_valid <= 1'b1;
    end
endmodule

// File: doc/picture_sprite.md
PICTURE_SPRITE -- requirements
Module: picture_sprite

Interface
REQ-001 Parameter WIDTH, default 72: sprite width in pixels.
REQ-002 Parameter HEIGHT, default 512: sprite height in lines.
REQ-003 Parameter FRAMES, default 4: number of animation frames stored back-to-back in the ROM.
REQ-004 Parameter ADDR_W, default 18: ROM address width. It SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT*FRAMES.
REQ-005 Parameter ROM_LAT, default 2: ROM read latency in clocks, range 1..4.
REQ-006 pixel_clk  in  1  sole clock; all logic samples on its rising edge.
REQ-007 reset  in  1  synchronous reset, active-high.
REQ-008 x  in  11  requested sprite left column.
REQ-009 y  in  10  requested sprite top line.
REQ-010 hcount  in  11  current raster column.
REQ-011 vcount  in  10  current raster line.
REQ-012 vsync  in  1  active-high vertical sync.
REQ-013 frame_sel  in  8  requested animation frame.
REQ-014 tint  in  24  colour multiplier, {R,G,B} at 8 bits each.
REQ-015 rom_addr  out  ADDR_W  registered ROM read address.
REQ-016 rom_data  in  8  ROM intensity; valid ROM_LAT clocks after rom_addr.
REQ-017 pixel  out  24  registered {R,G,B} output.
REQ-018 pixel_valid  out  1  high when pixel is an opaque sprite pixel.

Function
REQ-019 On the vsync 0->1 edge, x, y and frame_sel SHALL be latched into xl, yl and fl. fl SHALL be clamped to FRAMES-1 when frame_sel >= FRAMES. All later comparisons SHALL use only the latched values, so there is no mid-frame tearing.
REQ-020 in_box SHALL be defined as xl <= hcount < xl+WIDTH and yl <= vcount < yl+HEIGHT. Sums SHALL be computed at 12/11 bits, so a box extending past 2047/1023 clips and never wraps.
REQ-021 Registered one clock after hcount/vcount: when in_box, rom_addr SHALL = fl*WIDTH*HEIGHT + (vcount-yl)*WIDTH + (hcount-xl). When not in_box, rom_addr SHALL = fl*WIDTH*HEIGHT.
REQ-022 in_box SHALL be carried through a 1+ROM_LAT stage delay line aligned with rom_data.
REQ-023 pixel/pixel_valid SHALL be registered ROM_LAT+2 clocks after the corresponding hcount/vcount.
REQ-024 When the delayed in_box is 0: pixel = 0 and pixel_valid = 0.
REQ-025 When the delayed in_box is 1 and rom_data == 8'h00: pixel = 0 and pixel_valid = 0 (transparent key).
REQ-026 When the delayed in_box is 1 and rom_data != 0: each channel SHALL = (rom_data*(tint_ch+1))>>8, truncated to 8 bits, and pixel_valid = 1. tint = FFFFFF SHALL reproduce rom_data exactly on all channels.
REQ-027 tint SHALL be sampled in the same pipeline stage that consumes rom_data; it is not latched at vsync.
REQ-028 A vsync edge arriving while in_box pixels are still in the pipeline SHALL NOT corrupt them. Only addresses issued after the edge use the new latched values.
REQ-029 vsync held high SHALL latch only once per rising edge.

Reset
REQ-030 While reset is high at a clock edge: xl = yl = fl = 0; delay line cleared; rom_addr = 0; pixel = 0; pixel_valid = 0; vsync edge detector = 0.
REQ-031 Reset asserted mid-line SHALL suppress every in-flight pixel. Output SHALL resume ROM_LAT+2 clocks after reset deasserts.

Configuration
REQ-032 Macro PICTURE_SPRITE_MIRROR_EN.
- Defined: adds input port mirror (1 bit), latched at the vsync edge with the other controls. When the latched value is 1, the column term of REQ-021 becomes WIDTH-1-(hcount-xl).
- Undefined: the port is absent and no mirroring occurs.

Verification
REQ-033 WIDTH=4, HEIGHT=2, ROM_LAT=2; x=10, y=5 latched; raster at line 5. Required: rom_addr 0,1,2,3 for hcount 10..13; pixel_valid high exactly for hcount 10..13, shifted +4 clocks.
REQ-034 ROM returns 8'h80, tint = 24'hFF0040. Required: pixel = 24'h800020. ROM returns 00: pixel = 0 and pixel_valid = 0.
REQ-035 frame_sel = 9 with FRAMES = 4. Required: fl = 3, first in-box address = 3*WIDTH*HEIGHT. x changed mid-frame: box unchanged until the next vsync edge.
REQ-036 x = 2040, WIDTH = 72. Required: pixel_valid high only for hcount 2040..2047; no wrap to hcount 0.
REQ-037 Reset pulsed for 1 clock while in_box. Required: pixel_valid = 0 for ROM_LAT+2 clocks, then normal output.
REQ-038 With PICTURE_SPRITE_MIRROR_EN defined and mirror = 1, WIDTH = 4, line yl. Required: rom_addr 3,2,1,0 for hcount xl..xl+3.
